alu_seq_n_bits: RTL and testbench



---
 rtl/alu_seq_pkg.sv | 26 ++
 rtl/alu_seq_n_bits_iter_unit.sv | 63 ++++++
 rtl/sum_adder.sv | 14 +
 rtl/alu_seq_n_bits.sv | 161 ++++++++++++++++
 tb/tb_alu_seq_n_bits.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - opcode/state enums and width helper for the sequential ALU
package alu_seq_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SHL = 3'b101,
        ALU_MUL = 3'b110,
        ALU_DIV = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

    // Counter and shift-amount width; never below one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/alu_seq_n_bits_iter_unit.sv
// rtl/alu_seq_n_bits_iter_unit.sv - shift-add multiplier / restoring divider step (divider under ALU_DIV_EN)
module alu_iter_unit
    import alu_seq_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         step,
    input  logic         div_mode,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] lo_nx,
    output logic [N-1:0] hi_nx
);

    logic [N-1:0] lo;
    logic [N-1:0] hi;
    logic [N-1:0] dvs;
    logic [N:0]   mul_acc;
    logic [N-1:0] mul_lo;
    logic [N-1:0] mul_hi;

    // {hi, lo} holds partial product and remaining multiplier bits.
    assign mul_acc = {1'b0, hi} + (lo[0] ? {1'b0, dvs} : '0);
    assign mul_hi  = mul_acc[N:1];
    assign mul_lo  = {mul_acc[0], lo[N-1:1]};

`ifdef ALU_DIV_EN
    logic [N:0]   div_shift;
    logic [N-1:0] div_sub;
    logic         div_ok;

    // hi is the partial remainder, lo shifts dividend out and quotient in.
    assign div_shift = {hi, lo[N-1]};
    assign div_ok    = (div_shift >= {1'b0, dvs});
    assign div_sub   = div_shift[N-1:0] - dvs;
    assign lo_nx     = div_mode ? {lo[N-2:0], div_ok} : mul_lo;
    assign hi_nx     = div_mode ? (div_ok ? div_sub : div_shift[N-1:0]) : mul_hi;
`else
    logic unused_div_mode;
    assign unused_div_mode = div_mode;
    assign lo_nx = mul_lo;
    assign hi_nx = mul_hi;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lo  <= '0;
            hi  <= '0;
            dvs <= '0;
        end else if (load) begin
            lo  <= a;
            hi  <= '0;
            dvs <= b;
        end else if (step) begin
            lo  <= lo_nx;
            hi  <= hi_nx;
        end
    end

endmodule

// File: rtl/sum_adder.sv
// rtl/sum_adder.sv - N-bit ripple sum with carry in/out
module sum_adder #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};

endmodule

// File: rtl/alu_seq_n_bits.sv
// rtl/alu_seq_n_bits.sv - handshaked sequential N-bit ALU; define ALU_DIV_EN to build the divider
module alu_seq_n_bits
    import alu_seq_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [2:0]   control,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic [N-1:0] result_hi,
    output logic         v,
    output logic         c,
    output logic         n,
    output logic         z,
    output logic         e
);

    localparam int CW = cnt_width(N);

    alu_state_e    state;
    alu_state_e    state_nx;
    alu_op_e       op_in;
    alu_op_e       op_q;
    logic [CW-1:0] cnt;
    logic [N-1:0]  b_eff;
    logic [N-1:0]  add_sum;
    logic          add_cout;
    logic [N:0]    shl_wide;
    logic [N-1:0]  sc_res;
    logic [N-1:0]  sc_hi;
    logic          sc_c;
    logic          sc_v;
    logic          sc_e;
    logic          is_iter;
    logic          last_step;
    logic [N-1:0]  it_lo_nx;
    logic [N-1:0]  it_hi_nx;

    assign op_in     = alu_op_e'(control);
    assign b_eff     = control[0] ? ~b : b;
    // Bit N of the widened shift is the last bit pushed out of a.
    assign shl_wide  = {1'b0, a} << b[CW-1:0];
    assign last_step = (cnt == CW'(N - 1));
    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);

`ifdef ALU_DIV_EN
    assign is_iter = (op_in == ALU_MUL) || ((op_in == ALU_DIV) && (b != '0));
`else
    assign is_iter = (op_in == ALU_MUL);
`endif

    sum_adder #(.N(N)) u_sum (
        .a    (a),
        .b    (b_eff),
        .cin  (control[0]),
        .sum  (add_sum),
        .cout (add_cout)
    );

    alu_iter_unit #(.N(N)) u_iter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (in_ready && in_valid && is_iter),
        .step     (state == ST_CALC),
        .div_mode (op_q == ALU_DIV),
        .a        (a),
        .b        (b),
        .lo_nx    (it_lo_nx),
        .hi_nx    (it_hi_nx)
    );

    always_comb begin
        sc_res = '0;
        sc_hi  = '0;
        sc_c   = 1'b0;
        sc_v   = 1'b0;
        sc_e   = 1'b0;
        case (op_in)
            ALU_ADD, ALU_SUB: begin
                sc_res = add_sum;
                sc_c   = add_cout;
                sc_v   = (a[N-1] == b_eff[N-1]) && (add_sum[N-1] != a[N-1]);
            end
            ALU_AND: sc_res = a & b;
            ALU_OR:  sc_res = a | b;
            ALU_XOR: sc_res = a ^ b;
            ALU_SHL: begin
                sc_res = shl_wide[N-1:0];
                sc_c   = shl_wide[N];
            end
            ALU_DIV: begin
`ifdef ALU_DIV_EN
                sc_res = '1;
                sc_hi  = a;
`endif
                sc_e   = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (in_valid) state_nx = is_iter ? ST_CALC : ST_DONE;
            ST_CALC: if (last_step) state_nx = ST_DONE;
            ST_DONE: if (out_ready) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            op_q      <= ALU_ADD;
            result    <= '0;
            result_hi <= '0;
            v         <= 1'b0;
            c         <= 1'b0;
            n         <= 1'b0;
            z         <= 1'b0;
            e         <= 1'b0;
        end else begin
            state <= state_nx;
            if ((state == ST_IDLE) && in_valid) begin
                op_q <= op_in;
                cnt  <= '0;
                if (!is_iter) begin
                    result    <= sc_res;
                    result_hi <= sc_hi;
                    v         <= sc_v;
                    c         <= sc_c;
                    n         <= sc_res[N-1];
                    z         <= (sc_res == '0);
                    e         <= sc_e;
                end
            end else if (state == ST_CALC) begin
                cnt <= cnt + CW'(1);
                if (last_step) begin
                    result    <= it_lo_nx;
                    result_hi <= it_hi_nx;
                    v         <= (op_q == ALU_MUL) && (it_hi_nx != '0);
                    c         <= (op_q == ALU_MUL) && (it_hi_nx != '0);
                    n         <= it_lo_nx[N-1];
                    z         <= (it_lo_nx == '0);
                    e         <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_seq_n_bits.sv
// tb/tb_alu_seq_n_bits.sv - self-checking bench for alu_seq_n_bits (honours ALU_DIV_EN)
module tb_alu_seq_n_bits;

    localparam int N   = 4;
    localparam int SHW = $clog2(N);

    typedef struct packed {
        logic [N-1:0] res;
        logic [N-1:0] hi;
        logic         v;
        logic         c;
        logic         n;
        logic         z;
        logic         e;
        logic [7:0]   lat;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [2:0]   control;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] result;
    logic [N-1:0] result_hi;
    logic         v, c, n, z, e;

    int errors = 0;
    int checks = 0;

    alu_seq_n_bits #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .control   (control),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .result_hi (result_hi),
        .v         (v),
        .c         (c),
        .n         (n),
        .z         (z),
        .e         (e)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic ovf(input int s, input int m);
        return (s >= m / 2) || (s < -(m / 2));
    endfunction

    // Plain-integer reference for every opcode.
    function automatic exp_t model(input int ia, input int ib, input int op);
        exp_t ex;
        int m, r, h, sa, sb, s, sh;
        m  = 1 << N;
        r  = 0;
        h  = 0;
        ex = '0;
        ex.lat = 8'd1;
        sa = (ia >= m / 2) ? ia - m : ia;
        sb = (ib >= m / 2) ? ib - m : ib;
        case (op)
            0: begin
                s = ia + ib; r = s % m; ex.c = (s >= m);
                ex.v = ovf(sa + sb, m);
            end
            1: begin
                r = (ia - ib + m) % m; ex.c = (ia >= ib);
                ex.v = ovf(sa - sb, m);
            end
            2: r = ia & ib;
            3: r = ia | ib;
            4: r = ia ^ ib;
            5: begin
                sh = ib % (1 << SHW);
                r  = (ia * (1 << sh)) % m;
                ex.c = (sh > 0) && (sh <= N) && (((ia >> (N - sh)) & 1) != 0);
            end
            6: begin
                s = ia * ib; r = s % m; h = s / m;
                ex.c = (h != 0); ex.v = (h != 0); ex.lat = 8'(N + 1);
            end
            default: begin
`ifdef ALU_DIV_EN
                if (ib == 0) begin
                    r = m - 1; h = ia; ex.e = 1'b1;
                end else begin
                    r = ia / ib; h = ia % ib; ex.lat = 8'(N + 1);
                end
`else
                ex.e = 1'b1;
`endif
            end
        endcase
        ex.res = r[N-1:0];
        ex.hi  = h[N-1:0];
        ex.z   = (r == 0);
        ex.n   = (r >= m / 2);
        return ex;
    endfunction

    task automatic check_outputs(input string tag, input exp_t ex);
        check({tag, "_res"}, 32'(result), 32'(ex.res));
        check({tag, "_hi"}, 32'(result_hi), 32'(ex.hi));
        check({tag, "_vcnze"}, 32'({v, c, n, z, e}), 32'({ex.v, ex.c, ex.n, ex.z, ex.e}));
    endtask

    // Issue one operation, measure latency, check outputs and release.
    task automatic run_op(input int ia, input int ib, input int op, input string tag);
        exp_t ex;
        int   lat;
        ex = model(ia, ib, op);
        @(negedge clk);
        a = N'(ia); b = N'(ib); control = 3'(op); in_valid = 1'b1; out_ready = 1'b0;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            check({tag, "_busy"}, 32'(in_ready), 32'd0);
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(ex.lat));
        check_outputs(tag, ex);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_idle"}, 32'({out_valid, in_ready}), 32'b01);
    endtask

    initial begin
        exp_t ex;
        int   ra, rb, rop;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; control = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_hs", 32'({out_valid, in_ready}), 32'b01);
        check("reset_out", 32'({result, result_hi, v, c, n, z, e}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(4'b0111, 4'b0001, 0, "add_ovf");
        run_op(4'b0011, 4'b0011, 1, "sub_zero");
        run_op(4'b1011, 4'b0001, 5, "shl1");
        run_op(4'b1011, 4'b0000, 5, "shl0");
        run_op(4'b1100, 4'b1010, 2, "and");
        run_op(4'b1100, 4'b1010, 3, "or");
        run_op(4'b1100, 4'b1010, 4, "xor");
        run_op(4'b1111, 4'b1111, 6, "mul_max");
        run_op(4'b1101, 4'b0011, 7, "div");
        run_op(4'b0101, 4'b0000, 7, "div_zero");

        // Backpressure: result held, new request ignored until released.
        ex = model(4'b0110, 4'b0011, 0);
        @(negedge clk);
        a = 4'b0110; b = 4'b0011; control = 3'd0; in_valid = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a = 4'b0101; b = 4'b0101; control = 3'd1; in_valid = 1'b1; out_ready = 1'b0;
            @(posedge clk); #1;
            check("bp_hs", 32'({out_valid, in_ready}), 32'b10);
            check_outputs("bp_hold", ex);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release", 32'({out_valid, in_ready}), 32'b01);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;

        run_op(4'b0111, 4'b0001, 0, "pre_rst");

        // Reset in the middle of a multiply.
        @(negedge clk);
        a = 4'b1110; b = 4'b0111; control = 3'd6; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("calc_busy", 32'({out_valid, in_ready}), 32'b00);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_hs", 32'({out_valid, in_ready}), 32'b01);
        check("midrst_out", 32'({result, result_hi, v, c, n, z, e}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(4'b0010, 4'b0101, 0, "post_rst_add");

        for (int i = 0; i < 60; i++) begin
            ra  = int'($urandom_range(0, (1 << N) - 1));
            rb  = int'($urandom_range(0, (1 << N) - 1));
            rop = int'($urandom_range(0, 7));
            run_op(ra, rb, rop, $sformatf("rnd%0d_op%0d", i, rop));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
